sprite_mover: RTL and testbench

- Consumes the 1-cycle `game_clk` tick produced by the game-speed delay generator.
- On each accepted tick it moves one sprite by one pixel in the commanded direction.
- Each move is drawn as an erase/redraw pixel stream handed to the VGA plotter over a valid/ready handshake.
- Sits between the delay generator and the VGA adapter front end.

---
 rtl/sprite_mover.sv | 157 +++++++++++++++
 tb/tb_sprite_mover.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mover.sv
// sprite_mover
//
// Moves a square sprite by one pixel for each accepted game tick. Each move
// goes to the plotter as a pixel stream: the old footprint is erased in
// BG_COLOUR, the position is updated (clamped at the screen edges), and the
// new footprint is drawn in COLOUR.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   enable        gates acceptance of new ticks only
//   game_clk      single-cycle move tick, synchronous to clk
//   dir           00 right, 01 left, 10 down, 11 up
//   plot_ready    plotter accepts the current pixel
//   plot_valid    plot_x/plot_y/plot_colour hold a valid pixel
//   plot_x/y      pixel coordinates
//   plot_colour   pixel colour
//   x_pos/y_pos   current sprite top-left corner
//   busy          high whenever the FSM is not IDLE
//   hit_wall      one-cycle pulse when a move is blocked by a screen edge
//   dropped_ticks saturating count of ticks that arrived while busy
module sprite_mover #(
   parameter int         SCREEN_W    = 160,
   parameter int         SCREEN_H    = 120,
   parameter int         SPRITE_SIZE = 4,
   parameter logic [7:0] X_INIT      = 8'd0,
   parameter logic [6:0] Y_INIT      = 7'd0,
   parameter logic [2:0] COLOUR      = 3'b111,
   parameter logic [2:0] BG_COLOUR   = 3'b000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       game_clk,
   input  logic [1:0] dir,
   input  logic       plot_ready,
   output logic       plot_valid,
   output logic [7:0] plot_x,
   output logic [6:0] plot_y,
   output logic [2:0] plot_colour,
   output logic [7:0] x_pos,
   output logic [6:0] y_pos,
   output logic       busy,
   output logic       hit_wall,
   output logic [7:0] dropped_ticks
);

   // Counter halves: low half is the column offset, high half the row offset.
   localparam int HW = $clog2(SPRITE_SIZE);
   localparam int CW = 2 * HW;
   localparam logic [CW-1:0] LAST_PIX = '1;
   localparam logic [7:0] X_MAX = 8'(SCREEN_W - SPRITE_SIZE);
   localparam logic [6:0] Y_MAX = 7'(SCREEN_H - SPRITE_SIZE);

   typedef enum logic [1:0] {IDLE, ERASE, MOVE, DRAW} state_t;

   state_t        state;
   logic [1:0]    dir_q;
   logic [CW-1:0] pix_cnt;
   logic [CW-1:0] pix_next;
   logic [HW-1:0] cx_next;
   logic [HW-1:0] cy_next;
   logic [7:0]    new_x;
   logic [6:0]    new_y;
   logic          blocked;
   logic          xfer;
   logic          tick;

   assign tick     = game_clk && enable;
   assign xfer     = plot_valid && plot_ready;
   assign pix_next = pix_cnt + 1'b1;
   assign cx_next  = pix_next[HW-1:0];
   assign cy_next  = pix_next[CW-1:HW];
   assign busy     = (state != IDLE);

   // Clamped next position for the latched direction.
   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      new_x   = x_pos;
      new_y   = y_pos;
      blocked = 1'b0;
      unique case (dir_q)
         2'b00: if (x_pos < X_MAX) new_x = x_pos + 8'd1; else blocked = 1'b1;
         2'b01: if (x_pos > 8'd0)  new_x = x_pos - 8'd1; else blocked = 1'b1;
         2'b10: if (y_pos < Y_MAX) new_y = y_pos + 7'd1; else blocked = 1'b1;
         2'b11: if (y_pos > 7'd0)  new_y = y_pos - 7'd1; else blocked = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         dir_q         <= 2'b00;
         pix_cnt       <= '0;
         plot_valid    <= 1'b0;
         plot_x        <= 8'd0;
         plot_y        <= 7'd0;
         plot_colour   <= 3'b000;
         x_pos         <= X_INIT;
         y_pos         <= Y_INIT;
         hit_wall      <= 1'b0;
         dropped_ticks <= 8'd0;
      end else begin
         hit_wall <= 1'b0;

         if (tick && state != IDLE && dropped_ticks != 8'hFF)
            dropped_ticks <= dropped_ticks + 8'd1;

         unique case (state)
            IDLE: begin
               if (tick) begin
                  dir_q       <= dir;
                  state       <= ERASE;
                  pix_cnt     <= '0;
                  plot_valid  <= 1'b1;
                  plot_x      <= x_pos;
                  plot_y      <= y_pos;
                  plot_colour <= BG_COLOUR;
               end
            end

            // Erase and draw share the stream walk; x_pos/y_pos already hold
            // the footprint being emitted in either phase.
            ERASE, DRAW: begin
               if (xfer) begin
                  if (pix_cnt == LAST_PIX) begin
                     plot_valid <= 1'b0;
                     pix_cnt    <= '0;
                     state      <= (state == ERASE) ? MOVE : IDLE;
                  end else begin
                     pix_cnt <= pix_next;
                     plot_x  <= x_pos + 8'(cx_next);
                     plot_y  <= y_pos + 7'(cy_next);
                  end
               end
            end

            // Position update and the first draw pixel are loaded together,
            // so the draw stream starts right after this single cycle.
            MOVE: begin
               x_pos       <= new_x;
               y_pos       <= new_y;
               hit_wall    <= blocked;
               state       <= DRAW;
               pix_cnt     <= '0;
               plot_valid  <= 1'b1;
               plot_x      <= new_x;
               plot_y      <= new_y;
               plot_colour <= COLOUR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed testbench for sprite_mover. Instance a starts at (0,0); instance b
// starts at the right edge (156,0) to exercise a blocked move to the right.
module tb_sprite_mover;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       gca, gcb;
   logic [1:0] dir;
   logic       plot_ready;

   logic       a_valid, b_valid, a_busy, b_busy, a_hit, b_hit;
   logic [7:0] a_px, b_px, a_xpos, b_xpos, a_drop, b_drop;
   logic [6:0] a_py, b_py, a_ypos, b_ypos;
   logic [2:0] a_col, b_col;

   logic       sel;
   logic       o_valid, o_busy, o_hit;
   logic [7:0] o_px, o_xpos;
   logic [6:0] o_py, o_ypos;
   logic [2:0] o_col;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sprite_mover dut_a (
      .clk(clk), .reset(reset), .enable(enable), .game_clk(gca), .dir(dir),
      .plot_ready(plot_ready), .plot_valid(a_valid), .plot_x(a_px),
      .plot_y(a_py), .plot_colour(a_col), .x_pos(a_xpos), .y_pos(a_ypos),
      .busy(a_busy), .hit_wall(a_hit), .dropped_ticks(a_drop)
   );

   sprite_mover #(.X_INIT(8'd156), .Y_INIT(7'd0)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .game_clk(gcb), .dir(dir),
      .plot_ready(plot_ready), .plot_valid(b_valid), .plot_x(b_px),
      .plot_y(b_py), .plot_colour(b_col), .x_pos(b_xpos), .y_pos(b_ypos),
      .busy(b_busy), .hit_wall(b_hit), .dropped_ticks(b_drop)
   );

   assign o_valid = sel ? b_valid : a_valid;
   assign o_busy  = sel ? b_busy  : a_busy;
   assign o_hit   = sel ? b_hit   : a_hit;
   assign o_px    = sel ? b_px    : a_px;
   assign o_py    = sel ? b_py    : a_py;
   assign o_col   = sel ? b_col   : a_col;
   assign o_xpos  = sel ? b_xpos  : a_xpos;
   assign o_ypos  = sel ? b_ypos  : a_ypos;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pixel bundle {valid, x, y, colour} for compact comparisons.
   function automatic logic [18:0] pix(input logic v, input int x, input int y,
                                       input logic [2:0] c);
      return {v, 8'(x), 7'(y), c};
   endfunction

   function automatic logic [18:0] cur_pix();
      return {o_valid, o_px, o_py, o_col};
   endfunction

   // One move with plot_ready held high: tick in cycle T, erase on T+1..T+16,
   // MOVE at T+17, new position and draw on T+18..T+33, idle at T+34.
   // dir is switched to dir_after at T+3 to show the latched direction wins.
   task automatic run_move(input string tag, input int x0, input int y0,
                           input int x1, input int y1, input int hits,
                           input logic [1:0] dir_after);
      int nhit = 0;
      if (sel) gcb = 1'b1; else gca = 1'b1;
      step();
      gca = 1'b0;
      gcb = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         if (k == 3) dir = dir_after;
         if (o_hit) nhit++;
         if (k <= 16) begin
            check({tag, "_erase"}, cur_pix(),
                  pix(1'b1, x0 + (k-1)%4, y0 + (k-1)/4, 3'b000));
         end else if (k == 17) begin
            check({tag, "_move"}, {o_valid, o_busy}, 2'b01);
         end else begin
            if (k == 18) check({tag, "_pos"}, {o_xpos, o_ypos}, {8'(x1), 7'(y1)});
            check({tag, "_draw"}, cur_pix(),
                  pix(1'b1, x1 + (k-18)%4, y1 + (k-18)/4, 3'b111));
         end
         step();
      end
      check({tag, "_idle"}, {o_busy, o_valid}, 2'b00);
      check({tag, "_hits"}, nhit, hits);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, done_k, viol;
      logic stalled;
      logic [18:0] prev, exp;

      reset = 1'b1; enable = 1'b1; gca = 1'b0; gcb = 1'b0;
      dir = 2'b00; plot_ready = 1'b1; sel = 1'b0;
      step(); step();
      reset = 1'b0;
      step();

      // Reset state.
      check("rst_pix", cur_pix(), 19'd0);
      check("rst_pos", {a_xpos, a_ypos}, 15'd0);
      check("rst_flags", {a_busy, a_hit, a_drop}, 10'd0);
      check("rst_b_pos", {b_xpos, b_ypos}, {8'd156, 7'd0});

      // 1: plain move right from (0,0).
      run_move("t1", 0, 0, 1, 0, 0, 2'b00);

      // 2: blocked right at x=156, then blocked up at y=0.
      sel = 1'b1;
      run_move("t2r", 156, 0, 156, 0, 1, 2'b00);
      sel = 1'b0;
      dir = 2'b11;
      run_move("t2u", 1, 0, 1, 0, 1, 2'b11);

      // 3: plot_ready low on odd offsets, high on even. Erase transfers land
      // on T+2..T+32, MOVE at T+33, draw transfers on T+34..T+64, idle at T+65.
      dir = 2'b10;
      gca = 1'b1;
      step();
      gca = 1'b0;
      n = 0; done_k = 0; stalled = 1'b0; prev = '0;
      for (int k = 1; k <= 80; k++) begin
         plot_ready = (k % 2 == 0);
         if (stalled) check("t3_hold", cur_pix(), prev);
         if (done_k == 0 && !a_busy) done_k = k;
         if (a_valid && plot_ready) begin
            if (n < 16) exp = pix(1'b1, 1 + n%4, n/4, 3'b000);
            else        exp = pix(1'b1, 1 + (n-16)%4, 1 + (n-16)/4, 3'b111);
            check("t3_pix", cur_pix(), exp);
            n++;
         end
         stalled = a_valid && !plot_ready;
         prev = cur_pix();
         step();
      end
      plot_ready = 1'b1;
      check("t3_count", n, 32);
      check("t3_done", done_k, 65);

      // 4: second tick at T+5 is dropped; only one move (y 1 -> 2).
      gca = 1'b1;
      step();
      for (int k = 1; k <= 33; k++) begin
         gca = (k == 5);
         step();
      end
      check("t4_idle", a_busy, 1'b0);
      check("t4_drop", a_drop, 8'd1);
      check("t4_pos", {a_xpos, a_ypos}, {8'd1, 7'd2});
      step(); step();
      check("t4_one_move", {a_busy, a_ypos}, {1'b0, 7'd2});

      // 300 ticks with the plotter stalled: first is accepted, rest saturate.
      plot_ready = 1'b0;
      gca = 1'b1;
      repeat (300) step();
      gca = 1'b0;
      check("t4_sat", a_drop, 8'd255);
      check("t4_stall", {a_busy, a_valid}, 2'b11);
      reset = 1'b1;
      step();
      reset = 1'b0;
      plot_ready = 1'b1;
      step();
      check("t4_clr", {a_drop, a_xpos, a_ypos}, 23'd0);

      // 5: reset during draw pixel 7 (cx=3, cy=1 at new position (1,0)).
      dir = 2'b00;
      gca = 1'b1;
      step();
      gca = 1'b0;
      repeat (24) step();
      check("t5_pix7", cur_pix(), pix(1'b1, 4, 1, 3'b111));
      #2 reset = 1'b1;
      #1;
      check("t5_async", {a_valid, a_busy, a_xpos}, {1'b0, 1'b0, 8'd0});
      @(posedge clk);
      #1 reset = 1'b0;
      step();
      check("t5_quiet", {a_valid, a_busy}, 2'b00);
      run_move("t5", 0, 0, 1, 0, 0, 2'b00);

      // 6: enable low ignores ticks entirely.
      enable = 1'b0;
      viol = 0;
      for (int i = 0; i < 50; i++) begin
         gca = (i % 10 == 0);
         step();
         if (a_valid || a_busy) viol++;
      end
      gca = 1'b0;
      enable = 1'b1;
      check("t6_gated", viol, 0);
      check("t6_drop", a_drop, 8'd0);

      // Direction changed to left at T+3 is ignored: x goes 1 -> 2.
      run_move("t6_dir", 1, 0, 2, 0, 0, 2'b01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
